// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard and forwarding controller for the pipelined CPU.
// Tracks in-flight destinations in a DEPTH-stage shift pipeline (stage 1 = EX,
// stage DEPTH = WB). From that state it decodes the load-to-use stall, the IF/ID
// flush on a taken branch and the EX operand forward selects, all combinationally.
// Optional feature: define HAZ_STORE_FWD_EN to allow a store to follow the load
// that produces its data without a stall. The store data is then forwarded
// MEM->MEM, and the st_fwd port is present.
module hazard_fwd_ctrl #(
    parameter int unsigned RA_W       = 4,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_store,
    input  logic             br_taken,
    output logic             stall,
    output logic             if_id_flush,
    output logic [SEL_W-1:0] fwd_rs_sel,
    output logic [SEL_W-1:0] fwd_rt_sel
`ifdef HAZ_STORE_FWD_EN
    ,
    output logic             st_fwd
`endif
);

`ifdef HAZ_STORE_FWD_EN
    localparam bit STORE_FWD = 1'b1;
`else
    localparam bit STORE_FWD = 1'b0;
`endif

    // Stage holding the load that feeds a store sitting in stage 2.
    localparam int unsigned ST_LD = (DEPTH >= 3) ? 3 : DEPTH;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            wr;
        logic            load;
        logic            store;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            rs_used;
        logic            rt_used;
    } entry_t;

    entry_t pipe [1:DEPTH];
    entry_t id_entry;
    logic   issue;
    logic   hazard;
    logic   rs_done;
    logic   rt_done;
    logic   unused_state;

    // Entry s produces register r (r0 is hardwired zero and never matches).
    function automatic logic hit(input entry_t e, input logic [RA_W-1:0] r);
        return e.valid && e.wr && (e.rd == r) && (r != '0);
    endfunction

    // Pack the ID instruction into a pipeline entry.
    always_comb begin
        id_entry         = '0;
        id_entry.valid   = 1'b1;
        id_entry.rd      = id_rd;
        id_entry.wr      = id_wr;
        id_entry.load    = id_load;
        id_entry.store   = id_store;
        id_entry.rs      = id_rs;
        id_entry.rt      = id_rt;
        id_entry.rs_used = id_rs_used;
        id_entry.rt_used = id_rt_used;
    end

    // Load-to-use detection against loads whose data does not exist yet.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned s = 1; s < DEPTH; s++) begin
            if ((s < LOAD_STAGE) && pipe[s].load) begin
                if (id_rs_used && hit(pipe[s], id_rs)) begin
                    hazard = 1'b1;
                end
                if (id_rt_used && hit(pipe[s], id_rt) &&
                    !(STORE_FWD && id_store && (s == 1))) begin
                    hazard = 1'b1;
                end
            end
        end
        stall       = id_valid && !br_taken && hazard;
        if_id_flush = br_taken;
        issue       = id_valid && !stall && !br_taken;
    end

    // Youngest matching producer wins; a non-ready youngest match blocks older ones.
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        rs_done    = !(pipe[1].valid && pipe[1].rs_used);
        rt_done    = !(pipe[1].valid && pipe[1].rt_used);
        for (int unsigned s = 2; s <= DEPTH; s++) begin
            if (!rs_done && hit(pipe[s], pipe[1].rs)) begin
                rs_done = 1'b1;
                if (!pipe[s].load || (s >= LOAD_STAGE + 1)) begin
                    fwd_rs_sel = SEL_W'(s);
                end
            end
            if (!rt_done && hit(pipe[s], pipe[1].rt)) begin
                rt_done = 1'b1;
                if (!pipe[s].load || (s >= LOAD_STAGE + 1)) begin
                    fwd_rt_sel = SEL_W'(s);
                end
            end
        end
    end

`ifdef HAZ_STORE_FWD_EN
    // Store in MEM takes its data from the load one stage ahead of it.
    always_comb begin
        st_fwd = (DEPTH >= 3) && pipe[2].valid && pipe[2].store && pipe[2].rt_used &&
                 pipe[ST_LD].load && hit(pipe[ST_LD], pipe[2].rt);
    end
`endif

    // Fold of the whole pipeline; keeps tracked-but-unread fields visible.
    always_comb begin
        unused_state = 1'b0;
        for (int unsigned s = 1; s <= DEPTH; s++) begin
            unused_state = unused_state ^ (^pipe[s]);
        end
    end

    // Shift pipeline: stage 1 takes the issued instruction or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 1; s <= DEPTH; s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[1] <= issue ? id_entry : '0;
            for (int unsigned s = 2; s <= DEPTH; s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl with RA_W=4, DEPTH=3, LOAD_STAGE=2.
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [3:0] id_rd;
    logic       id_wr;
    logic       id_load;
    logic       id_store;
    logic       br_taken;
    logic       stall;
    logic       if_id_flush;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
`ifdef HAZ_STORE_FWD_EN
    logic       st_fwd;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_fwd_ctrl #(.RA_W(4), .DEPTH(3), .LOAD_STAGE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_rd      (id_rd),
        .id_wr      (id_wr),
        .id_load    (id_load),
        .id_store   (id_store),
        .br_taken   (br_taken),
        .stall      (stall),
        .if_id_flush(if_id_flush),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel)
`ifdef HAZ_STORE_FWD_EN
        ,
        .st_fwd     (st_fwd)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic id_set(input int unsigned rs, input int unsigned rt,
                          input int unsigned rsu, input int unsigned rtu,
                          input int unsigned rd, input int unsigned wr,
                          input int unsigned ld, input int unsigned st);
        id_valid   = 1'b1;
        id_rs      = 4'(rs);
        id_rt      = 4'(rt);
        id_rs_used = 1'(rsu);
        id_rt_used = 1'(rtu);
        id_rd      = 4'(rd);
        id_wr      = 1'(wr);
        id_load    = 1'(ld);
        id_store   = 1'(st);
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_rs      = 4'd0;
        id_rt      = 4'd0;
        id_rs_used = 1'b0;
        id_rt_used = 1'b0;
        id_rd      = 4'd0;
        id_wr      = 1'b0;
        id_load    = 1'b0;
        id_store   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        br_taken = 1'b0;
        idle();
        #2;
        chk("rst.stall", 32'(stall), 0);
        chk("rst.flush", 32'(if_id_flush), 0);
        chk("rst.rs", 32'(fwd_rs_sel), 0);
        chk("rst.rt", 32'(fwd_rt_sel), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ADD r3,r1,r2 ; ADD r4,r3,r3 : distance-1 ALU forward from stage 2
        id_set(1, 2, 1, 1, 3, 1, 0, 0);
        #1 chk("A.stall0", 32'(stall), 0);
        tick();
        id_set(3, 3, 1, 1, 4, 1, 0, 0);
        #1 chk("A.stall1", 32'(stall), 0);
        tick();
        idle();
        #1;
        chk("A.rs2", 32'(fwd_rs_sel), 2);
        chk("A.rt2", 32'(fwd_rt_sel), 2);
        tick();
        // ADD r11,r3,r4 two slots later: r4 from stage 3, r3 already retired
        id_set(3, 4, 1, 1, 11, 1, 0, 0);
        tick();
        idle();
        #1;
        chk("A.rs_retired", 32'(fwd_rs_sel), 0);
        chk("A.rt3", 32'(fwd_rt_sel), 3);
        drain();

        // LW r4 ; ADD r5,r4,r1 : one bubble, then forward from stage 3
        id_set(1, 0, 1, 0, 4, 1, 1, 0);
        #1 chk("B.lw_nostall", 32'(stall), 0);
        tick();
        id_set(4, 1, 1, 1, 5, 1, 0, 0);
        #1;
        chk("B.stall", 32'(stall), 1);
        chk("B.lw_rs", 32'(fwd_rs_sel), 0);
        tick();
        #1 chk("B.stall_once", 32'(stall), 0);
        tick();
        idle();
        #1;
        chk("B.rs3", 32'(fwd_rs_sel), 3);
        chk("B.rt0", 32'(fwd_rt_sel), 0);
        drain();

        // ADD r6 ; ADD r6 ; SUB r7,r6,r0 : youngest producer, r0 never forwards
        id_set(1, 2, 1, 1, 6, 1, 0, 0);
        tick();
        id_set(1, 2, 1, 1, 6, 1, 0, 0);
        tick();
        id_set(6, 0, 1, 1, 7, 1, 0, 0);
        #1 chk("C.stall", 32'(stall), 0);
        tick();
        idle();
        #1;
        chk("C.rs_young", 32'(fwd_rs_sel), 2);
        chk("C.rt_r0", 32'(fwd_rt_sel), 0);
        drain();
        // ADD r0,r1,r2 ; ADD r12,r0,r0 : writer of r0 is never matched
        id_set(1, 2, 1, 1, 0, 1, 0, 0);
        tick();
        id_set(0, 0, 1, 1, 12, 1, 0, 0);
        tick();
        idle();
        #1;
        chk("C.r0_rs", 32'(fwd_rs_sel), 0);
        chk("C.r0_rt", 32'(fwd_rt_sel), 0);
        drain();

        // LW r2 in EX, ID ADD r9,r2,r2 with taken branch: flush wins, ID killed
        id_set(1, 0, 1, 0, 2, 1, 1, 0);
        tick();
        id_set(2, 2, 1, 1, 9, 1, 0, 0);
        br_taken = 1'b1;
        #1;
        chk("D.stall", 32'(stall), 0);
        chk("D.flush", 32'(if_id_flush), 1);
        tick();
        br_taken = 1'b0;
        id_set(9, 0, 1, 0, 10, 1, 0, 0);
        #1;
        chk("D.flush_off", 32'(if_id_flush), 0);
        chk("D.stall_off", 32'(stall), 0);
        tick();
        idle();
        #1 chk("D.killed", 32'(fwd_rs_sel), 0);
        drain();

        // LW r8 ; SW r8 (store data in rt)
        id_set(1, 0, 1, 0, 8, 1, 1, 0);
        tick();
        id_set(1, 8, 1, 1, 0, 0, 0, 1);
`ifdef HAZ_STORE_FWD_EN
        #1 chk("E.no_stall", 32'(stall), 0);
        tick();
        idle();
        #1 chk("E.st_fwd_early", 32'(st_fwd), 0);
        tick();
        #1 chk("E.st_fwd", 32'(st_fwd), 1);
`else
        #1 chk("E.stall", 32'(stall), 1);
        tick();
        #1 chk("E.stall_once", 32'(stall), 0);
        tick();
        idle();
        #1 chk("E.rt3", 32'(fwd_rt_sel), 3);
`endif
        drain();

        // Fill with writers, then async reset mid-cycle
        id_set(1, 2, 1, 1, 5, 1, 0, 0);
        tick();
        id_set(5, 5, 1, 1, 6, 1, 0, 0);
        tick();
        id_set(6, 0, 1, 0, 7, 1, 1, 0);
        tick();
        id_set(7, 7, 1, 1, 8, 1, 0, 0);
        #1;
        chk("F.pre_stall", 32'(stall), 1);
        chk("F.pre_rs", 32'(fwd_rs_sel), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("F.rst_stall", 32'(stall), 0);
        chk("F.rst_flush", 32'(if_id_flush), 0);
        chk("F.rst_rs", 32'(fwd_rs_sel), 0);
        chk("F.rst_rt", 32'(fwd_rt_sel), 0);
        tick();
        chk("F.hold_stall", 32'(stall), 0);
        chk("F.hold_rs", 32'(fwd_rs_sel), 0);
        idle();
        rst_n = 1'b1;
        tick();
        chk("F.post_rs", 32'(fwd_rs_sel), 0);
        chk("F.post_stall", 32'(stall), 0);
        id_set(1, 2, 1, 1, 9, 1, 0, 0);
        #1 chk("F.new_stall", 32'(stall), 0);
        tick();
        id_set(9, 9, 1, 1, 10, 1, 0, 0);
        tick();
        idle();
        #1;
        chk("F.new_rs", 32'(fwd_rs_sel), 2);
        chk("F.new_rt", 32'(fwd_rt_sel), 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
